// File: rtl/bf8b_pkg.sv
// Shared bf8b types: memory arbiter state and access owner.
// The core's debug trace reuses these enums.
package bf8b_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of arbitrations a pending fetch has lost to the LSU.
// force_if is raised once the count reaches STARVE_MAX.
module mem_arb_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic force_if
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CW'(STARVE_MAX))) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign force_if = (cnt == CW'(STARVE_MAX));

endmodule

// File: rtl/mem_arbiter.sv
// Shares one registered-read memory port between instruction fetch and the LSU.
// Each access takes two cycles: ACCESS drives the memory, RESP returns data and re-arbitrates.
//
// state  | meaning
// IDLE   | no access in flight; arbitration point
// ACCESS | mem_* driven, memory samples at the end of this cycle
// RESP   | owner's rvalid high, mem_rdata valid; arbitration point
module mem_arbiter
  import bf8b_pkg::*;
#(
  parameter int M_WIDTH    = 32,
  parameter int ADDR_W     = 30,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_req,
  input  logic [ADDR_W-1:0]    if_addr,
  output logic                 if_gnt,
  output logic                 if_rvalid,
  output logic [M_WIDTH-1:0]   if_rdata,
  input  logic                 ls_req,
  input  logic [ADDR_W-1:0]    ls_addr,
  input  logic [M_WIDTH-1:0]   ls_wdata,
  input  logic [M_WIDTH/8-1:0] ls_wes,
  output logic                 ls_gnt,
  output logic                 ls_rvalid,
  output logic [M_WIDTH-1:0]   ls_rdata,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [M_WIDTH-1:0]   mem_wdata,
  output logic [M_WIDTH/8-1:0] mem_wes,
  input  logic [M_WIDTH-1:0]   mem_rdata
);

  arb_state_e state, state_nxt;
  owner_e     owner;
  logic       arb_point;
  logic       if_win;
  logic       ls_win;
  logic       force_if;
  logic       starve_inc;
  logic       starve_clr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    arb_point = (state == IDLE) || (state == RESP);
    if_win    = 1'b0;
    ls_win    = 1'b0;
    if (arb_point) begin
      // LSU wins unless fetch has been starved long enough.
      if_win = if_req && (!ls_req || force_if);
      ls_win = ls_req && !if_win;
    end
    case (state)
      IDLE:    state_nxt = (if_win || ls_win) ? ACCESS : IDLE;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = (if_win || ls_win) ? ACCESS : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign if_gnt    = if_win;
  assign ls_gnt    = ls_win;
  assign if_rvalid = (state == RESP) && (owner == OWN_IF);
  assign ls_rvalid = (state == RESP) && (owner == OWN_LS);
  assign if_rdata  = mem_rdata;
  assign ls_rdata  = mem_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wes   <= '0;
      owner     <= OWN_IF;
    end else if (if_win) begin
      // Fetch never writes, whatever the LSU leaves on ls_wes.
      mem_addr <= if_addr;
      mem_wes  <= '0;
      owner    <= OWN_IF;
    end else if (ls_win) begin
      mem_addr  <= ls_addr;
      mem_wdata <= ls_wdata;
      mem_wes   <= ls_wes;
      owner     <= OWN_LS;
    end else if (state == ACCESS) begin
      mem_wes <= '0;
    end
  end

  assign starve_inc = arb_point && if_req && ls_win;
  assign starve_clr = arb_point && (if_win || !if_req);

  mem_arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve_ctr (
    .clk      (clk),
    .rst      (rst),
    .clr      (starve_clr),
    .inc      (starve_inc),
    .force_if (force_if)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a registered-read byte-writable memory model.
// Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
module tb_mem_arbiter;

  localparam int M_WIDTH    = 32;
  localparam int ADDR_W     = 30;
  localparam int NB         = M_WIDTH / 8;
  localparam int STARVE_MAX = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               if_req = 1'b0;
  logic [ADDR_W-1:0]  if_addr = '0;
  logic               if_gnt, if_rvalid;
  logic [M_WIDTH-1:0] if_rdata;
  logic               ls_req = 1'b0;
  logic [ADDR_W-1:0]  ls_addr = '0;
  logic [M_WIDTH-1:0] ls_wdata = '0;
  logic [NB-1:0]      ls_wes = '0;
  logic               ls_gnt, ls_rvalid;
  logic [M_WIDTH-1:0] ls_rdata;
  logic [ADDR_W-1:0]  mem_addr;
  logic [M_WIDTH-1:0] mem_wdata;
  logic [NB-1:0]      mem_wes;
  logic [M_WIDTH-1:0] mem_rdata = '0;

  logic [M_WIDTH-1:0] mem [256];

  int checks = 0;
  int errors = 0;

  mem_arbiter #(
    .M_WIDTH(M_WIDTH), .ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_wes(ls_wes),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wes(mem_wes),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr[7:0]];
    for (int b = 0; b < NB; b++)
      if (mem_wes[b]) mem[mem_addr[7:0]][8*b +: 8] = mem_wdata[8*b +: 8];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({if_gnt, ls_gnt, if_rvalid, ls_rvalid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_handshake got %b want 0000", {if_gnt, ls_gnt, if_rvalid, ls_rvalid});
    end
    checks++;
    if (mem_addr !== '0 || mem_wdata !== '0 || mem_wes !== '0) begin
      errors++;
      $display("FAIL reset_mem got addr=%h wdata=%h wes=%b want zeros", mem_addr, mem_wdata, mem_wes);
    end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_fetch_alone();
    if_req = 1'b1; if_addr = 30'h38;
    #1;
    checks++;
    if (if_gnt !== 1'b1 || ls_gnt !== 1'b0) begin
      errors++;
      $display("FAIL fetch_gnt got if=%b ls=%b want 1 0", if_gnt, ls_gnt);
    end
    tick();
    if_req = 1'b0;
    #1;
    checks++;
    if (mem_addr !== 30'h38 || mem_wes !== 4'b0000 || if_gnt !== 1'b0) begin
      errors++;
      $display("FAIL fetch_access got addr=%h wes=%b gnt=%b want 38 0000 0", mem_addr, mem_wes, if_gnt);
    end
    tick();
    #1;
    checks++;
    if (if_rvalid !== 1'b1 || ls_rvalid !== 1'b0 || if_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL fetch_resp got rv=%b lsrv=%b data=%h want 1 0 deadbeef", if_rvalid, ls_rvalid, if_rdata);
    end
    tick();
    #1;
    checks++;
    if (if_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL fetch_rvalid_pulse got %b want 0", if_rvalid);
    end
  endtask

  task automatic test_store_load();
    ls_req = 1'b1; ls_addr = 30'h38; ls_wes = 4'b0010; ls_wdata = 32'h0000AB00;
    #1;
    checks++;
    if (ls_gnt !== 1'b1) begin
      errors++;
      $display("FAIL store_gnt got %b want 1", ls_gnt);
    end
    tick();
    ls_req = 1'b0;
    #1;
    checks++;
    if (mem_wes !== 4'b0010 || mem_wdata !== 32'h0000AB00) begin
      errors++;
      $display("FAIL store_access got wes=%b wdata=%h want 0010 0000ab00", mem_wes, mem_wdata);
    end
    tick();
    ls_req = 1'b1; ls_wes = 4'b0000; ls_wdata = 32'h0;
    #1;
    checks++;
    if (ls_rvalid !== 1'b1 || mem_wes !== 4'b0000 || ls_gnt !== 1'b1) begin
      errors++;
      $display("FAIL store_resp got rv=%b wes=%b gnt=%b want 1 0000 1", ls_rvalid, mem_wes, ls_gnt);
    end
    tick();
    ls_req = 1'b0;
    #1;
    checks++;
    if (mem_wes !== 4'b0000 || ls_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL load_access got wes=%b rv=%b want 0000 0", mem_wes, ls_rvalid);
    end
    tick();
    #1;
    checks++;
    if (ls_rvalid !== 1'b1 || ls_rdata !== 32'hDEADABEF) begin
      errors++;
      $display("FAIL load_resp got rv=%b data=%h want 1 deadabef", ls_rvalid, ls_rdata);
    end
    tick();
  endtask

  task automatic test_simultaneous();
    if_req = 1'b1; if_addr = 30'h10;
    ls_req = 1'b1; ls_addr = 30'h11; ls_wes = 4'b0000;
    #1;
    checks++;
    if (ls_gnt !== 1'b1 || if_gnt !== 1'b0) begin
      errors++;
      $display("FAIL simul_first got ls=%b if=%b want 1 0", ls_gnt, if_gnt);
    end
    tick();
    ls_req = 1'b0;
    #1;
    checks++;
    if (if_gnt !== 1'b0 || ls_gnt !== 1'b0) begin
      errors++;
      $display("FAIL simul_no_early got if=%b ls=%b want 0 0", if_gnt, ls_gnt);
    end
    tick();
    #1;
    checks++;
    if (ls_rvalid !== 1'b1 || if_gnt !== 1'b1 || ls_gnt !== 1'b0) begin
      errors++;
      $display("FAIL simul_second got lsrv=%b if=%b ls=%b want 1 1 0", ls_rvalid, if_gnt, ls_gnt);
    end
    tick();
    if_req = 1'b0;
    tick();
    #1;
    checks++;
    if (if_rvalid !== 1'b1 || ls_rvalid !== 1'b0 || mem_addr !== 30'h10) begin
      errors++;
      $display("FAIL simul_if_resp got rv=%b lsrv=%b addr=%h want 1 0 10", if_rvalid, ls_rvalid, mem_addr);
    end
    tick();
  endtask

  task automatic test_starvation();
    logic [1:0] want;
    if_req = 1'b1; if_addr = 30'h20;
    ls_req = 1'b1; ls_addr = 30'h21; ls_wes = 4'b0000;
    for (int k = 0; k < 6; k++) begin
      #1;
      want = (k == 4) ? 2'b10 : 2'b01;
      checks++;
      if ({if_gnt, ls_gnt} !== want) begin
        errors++;
        $display("FAIL starve_arb%0d got if/ls=%b want %b", k, {if_gnt, ls_gnt}, want);
      end
      tick();
      if (k == 4) if_req = 1'b0;
      tick();
    end
    ls_req = 1'b0;
    #1;
    checks++;
    if (ls_rvalid !== 1'b1 || if_gnt !== 1'b0 || ls_gnt !== 1'b0) begin
      errors++;
      $display("FAIL starve_tail got lsrv=%b if=%b ls=%b want 1 0 0", ls_rvalid, if_gnt, ls_gnt);
    end
    tick();
  endtask

  task automatic test_stray_wes();
    if_req = 1'b1; if_addr = 30'h38;
    ls_req = 1'b0; ls_wes = 4'b1111; ls_wdata = 32'hFFFFFFFF;
    #1;
    checks++;
    if (if_gnt !== 1'b1) begin
      errors++;
      $display("FAIL stray_gnt got %b want 1", if_gnt);
    end
    tick();
    if_req = 1'b0;
    #1;
    checks++;
    if (mem_wes !== 4'b0000) begin
      errors++;
      $display("FAIL stray_wes got %b want 0000", mem_wes);
    end
    tick();
    #1;
    checks++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEADABEF) begin
      errors++;
      $display("FAIL stray_data got rv=%b data=%h want 1 deadabef", if_rvalid, if_rdata);
    end
    tick();
    ls_wes = 4'b0000; ls_wdata = '0;
  endtask

  task automatic test_reset_mid_store();
    ls_req = 1'b1; ls_addr = 30'h38; ls_wes = 4'b1111; ls_wdata = 32'h12345678;
    #1;
    checks++;
    if (ls_gnt !== 1'b1) begin
      errors++;
      $display("FAIL rst_store_gnt got %b want 1", ls_gnt);
    end
    tick();
    ls_req = 1'b0; ls_wes = 4'b0000;
    #1;
    checks++;
    if (mem_wes !== 4'b1111) begin
      errors++;
      $display("FAIL rst_store_access got %b want 1111", mem_wes);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (mem_wes !== 4'b0000 || mem_addr !== '0 || {ls_gnt, ls_rvalid, if_gnt, if_rvalid} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_async got wes=%b addr=%h hs=%b want 0000 0 0000",
               mem_wes, mem_addr, {ls_gnt, ls_rvalid, if_gnt, if_rvalid});
    end
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (ls_rvalid !== 1'b0 || if_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_rvalid got ls=%b if=%b want 0 0", ls_rvalid, if_rvalid);
    end
    tick();
    ls_req = 1'b1; ls_addr = 30'h38; ls_wes = 4'b0000;
    #1;
    checks++;
    if (ls_gnt !== 1'b1) begin
      errors++;
      $display("FAIL rst_idle_gnt got %b want 1", ls_gnt);
    end
    tick();
    ls_req = 1'b0;
    tick();
    #1;
    checks++;
    if (ls_rvalid !== 1'b1 || ls_rdata !== 32'hDEADABEF) begin
      errors++;
      $display("FAIL rst_no_write got rv=%b data=%h want 1 deadabef", ls_rvalid, ls_rdata);
    end
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h38] = 32'hDEADBEEF;
    test_reset();
    test_fetch_alone();
    test_store_load();
    test_simultaneous();
    test_starvation();
    test_stray_wes();
    test_reset_mid_store();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

endmodule
